// File: rtl/nn_frame_capture.sv
// Pixel stream capture and binarization in front of the nn classifier.
// Holds a 784-bit frame, waits a settle interval, then latches the prediction.
module nn_frame_capture #(
  parameter int PIX_W         = 8,
  parameter int THRESHOLD     = 128,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_sof,
  output logic             frame [784],
  input  logic [4:0]       nn_prediction,
  output logic [4:0]       result,
  output logic             result_valid,
  input  logic             result_ack
);

  localparam int CW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(SETTLE_CYCLES - 1);
  localparam logic [PIX_W:0] THR = (PIX_W+1)'(THRESHOLD);

  typedef enum logic [1:0] {
    FILL,
    SETTLE,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [9:0]    idx, idx_nxt, wr_idx;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept;
  logic          bit_val;
  logic          last;
  logic          fire;
  logic          take;

  assign pix_ready = (state == FILL) && !Reset;
  assign accept    = pix_valid && pix_ready;
  assign wr_idx    = pix_sof ? 10'd0 : idx;
  assign bit_val   = {1'b0, pix_data} >= THR;
  assign last      = (wr_idx == 10'd783);
  assign fire      = (state == SETTLE) && (cnt == '0);
  assign take      = (state == DONE) && result_valid
                     && result_ack;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    unique case (state)
      FILL: begin
        if (accept) begin
          idx_nxt = pix_sof ? 10'd1 : idx + 10'd1;
          if (last) begin
            state_nxt = SETTLE;
            idx_nxt   = 10'd0;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      SETTLE: begin
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      DONE: begin
        if (take) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= FILL;
      idx          <= 10'd0;
      cnt          <= '0;
      result       <= 5'd0;
      result_valid <= 1'b0;
      for (int i = 0; i < 784; i++) frame[i] <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      if (accept) frame[wr_idx] <= bit_val;
      // prediction sampled only after the frame sat still
      if (fire) begin
        result       <= nn_prediction;
        result_valid <= 1'b1;
      end
      if (take) result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nn_frame_capture.sv
// Bench for nn_frame_capture: transaction-level model of frame capture
// plus a directed check of a SETTLE_CYCLES=1 build.
module tb_nn_frame_capture;

  localparam int S = 16;

  logic       clk = 1'b0;
  logic       rst, pv, ps, pr, rv, ack;
  logic [7:0] pd;
  logic [4:0] pred, res;
  logic       frm [784];

  logic       rst1, pv1, ps1, pr1, rv1, ack1;
  logic [7:0] pd1;
  logic [4:0] pred1, res1;
  logic       frm1 [784];

  always #5 clk = ~clk;

  nn_frame_capture #(
    .PIX_W(8), .THRESHOLD(128), .SETTLE_CYCLES(S)
  ) dut (
    .Clk(clk), .Reset(rst), .pix_valid(pv), .pix_ready(pr),
    .pix_data(pd), .pix_sof(ps), .frame(frm),
    .nn_prediction(pred), .result(res),
    .result_valid(rv), .result_ack(ack)
  );

  nn_frame_capture #(
    .PIX_W(8), .THRESHOLD(128), .SETTLE_CYCLES(1)
  ) dut1 (
    .Clk(clk), .Reset(rst1), .pix_valid(pv1), .pix_ready(pr1),
    .pix_data(pd1), .pix_sof(ps1), .frame(frm1),
    .nn_prediction(pred1), .result(res1),
    .result_valid(rv1), .result_ack(ack1)
  );

  // reference model: image contents and frame lifecycle in cycle numbers
  bit         mf [784];
  int         m_idx   = 0;
  int         m_beats = 0;
  int         cyc     = 0;
  int         done_at = 0;
  bit         m_busy  = 0;
  bit         m_valid = 0;
  logic [4:0] m_res   = 5'd0;

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_frame();
    int diff = 0;
    for (int i = 0; i < 784; i++)
      if (frm[i] !== mf[i]) diff++;
    chk("frame_bits_differing", diff, 0);
  endtask

  task automatic step(input bit v, input logic [7:0] d,
                      input bit sof, input bit a, input bit r);
    int wi;
    @(negedge clk);
    pv = v; pd = d; ps = sof; ack = a; rst = r;
    #1;
    chk("pix_ready", pr, {31'd0, !r && !m_busy});
    @(posedge clk);
    cyc++;
    if (r) begin
      foreach (mf[i]) mf[i] = 1'b0;
      m_idx = 0; m_busy = 0; m_valid = 0; m_res = 5'd0;
    end else if (!m_busy) begin
      if (v) begin
        wi = sof ? 0 : m_idx;
        mf[wi] = (d >= 8'd128);
        m_idx = sof ? 1 : m_idx + 1;
        m_beats++;
        if (wi == 783) begin
          m_busy = 1; m_idx = 0; done_at = cyc + S;
        end
      end
    end else if (!m_valid && cyc == done_at) begin
      m_valid = 1; m_res = pred;
    end else if (m_valid && a) begin
      m_valid = 0; m_busy = 0;
    end
    #1;
    chk("result_valid", rv, {31'd0, m_valid});
    chk("result", res, {27'd0, m_res});
    chk_frame();
  endtask

  // mode 0: 127/128/255/0 pattern, 1: random, 2: fixed value
  task automatic send(input int n, input bit sof_first,
                      input int bubble, input int mode,
                      input logic [7:0] fixed);
    int got = 0;
    int guard = 0;
    logic [7:0] d;
    logic [7:0] pat [4];
    pat[0] = 8'd127; pat[1] = 8'd128;
    pat[2] = 8'd255; pat[3] = 8'd0;
    d = 8'd0;
    while (got < n && guard < 5000) begin
      int pre;
      bit v;
      guard++;
      v = ($urandom_range(0, 99) >= bubble);
      if (mode == 0)      d = pat[got % 4];
      else if (mode == 2) d = fixed;
      else if (v)         d = 8'($urandom_range(0, 255));
      pre = m_beats;
      step(v, d, sof_first && got == 0,
           $urandom_range(0, 3) == 0, 1'b0);
      if (m_beats > pre) got++;
    end
    if (guard >= 5000) chk("send_timeout", 1, 0);
  endtask

  task automatic wait_result();
    int guard = 0;
    while (!m_valid && guard < 200) begin
      guard++;
      step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    end
    if (!m_valid) chk("result_timeout", 1, 0);
  endtask

  initial begin
    rst = 1; pv = 0; ps = 0; pd = 0; ack = 0; pred = 5'd7;
    rst1 = 1; pv1 = 0; ps1 = 0; pd1 = 0; ack1 = 0; pred1 = 5'd0;

    // reset held with valid offered
    repeat (3) step(1'b1, 8'd200, 1'b0, 1'b0, 1'b1);

    // threshold boundary frame, continuous valid
    send(784, 1'b1, 0, 0, 8'd0);
    chk("frame0_127", frm[400], 0);
    chk("frame1_128", frm[401], 1);
    chk("frame2_255", frm[402], 1);
    chk("frame3_0", frm[403], 0);
    // ack pulses during settle must be ignored
    repeat (4) step(1'b1, 8'd255, 1'b0, 1'b1, 1'b0);
    wait_result();
    chk("first_result", res, 7);

    // backpressure: result held, prediction moves
    repeat (25) step(1'b1, 8'd9, 1'b0, 1'b0, 1'b0);
    pred = 5'd3;
    repeat (25) step(1'b1, 8'd9, 1'b0, 1'b0, 1'b0);
    chk("held_result", res, 7);
    step(1'b1, 8'd9, 1'b0, 1'b1, 1'b0);
    chk("ack_drops_valid", rv, 0);

    // bubbles, then sof resync mid-frame
    pred = 5'd19;
    send(300, 1'b1, 40, 1, 8'd0);
    send(1, 1'b1, 40, 2, 8'd200);
    chk("sof_bit0", frm[0], 1);
    chk("sof_idx", dut.idx, 1);
    send(783, 1'b0, 40, 1, 8'd0);
    wait_result();
    chk("resync_result", res, 19);
    step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);

    // reset in the middle of settle
    pred = 5'd11;
    send(784, 1'b1, 0, 1, 8'd0);
    repeat (10) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    chk("settle_cnt_5", dut.cnt, 5);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    repeat (30) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    chk("no_result_after_reset", rv, 0);

    // a clean frame after the reset
    pred = 5'd25;
    send(784, 1'b1, 20, 1, 8'd0);
    wait_result();
    chk("post_reset_result", res, 25);
    step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);

    // SETTLE_CYCLES=1 build
    @(negedge clk); rst1 = 1; pv1 = 1;
    @(posedge clk);
    @(negedge clk); rst1 = 0;
    for (int i = 0; i < 784; i++) begin
      if (i > 0) @(negedge clk);
      pd1 = (i % 2 == 1) ? 8'd200 : 8'd10;
      ps1 = (i == 0);
      pred1 = 5'd9;
      #1;
      chk("s1_ready", pr1, 1);
      @(posedge clk);
      #1;
      chk("s1_valid_low", rv1, 0);
    end
    @(negedge clk); pv1 = 0; pred1 = 5'd21;
    #1;
    chk("s1_ready_low", pr1, 0);
    @(posedge clk); #1;
    chk("s1_valid", rv1, 1);
    chk("s1_result", res1, 21);
    @(negedge clk); pred1 = 5'd4;
    @(posedge clk); #1;
    chk("s1_result_held", res1, 21);
    chk("s1_frame0", frm1[0], 0);
    chk("s1_frame783", frm1[783], 1);
    @(negedge clk); ack1 = 1;
    @(posedge clk); #1;
    chk("s1_acked", rv1, 0);
    chk("s1_ready_again", pr1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
